// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle for fetch_queue
//
// Groups the fetch-side enqueue handshake, the decode-side dequeue handshake
// and the queue status outputs.
//   master : fetch/decode side (drives in_*, out_ready; observes the rest)
//   slave  : the queue itself
interface fetch_queue_if #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
);
  logic             in_valid;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic [31:0]      in_npc;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [31:0]      out_npc;
  logic             out_ready;
  logic [PTR_W:0]   count;
  logic             wfi_seen;

  modport master (
    output in_valid, in_inst, in_pc, in_npc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_npc, count, wfi_seen
  );

  modport slave (
    input  in_valid, in_inst, in_pc, in_npc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_npc, count, wfi_seen
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - registered instruction FIFO between fetch and decode
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   flush : synchronous clear of all entries (mispredict recovery)
//   q     : fetch_queue_if.slave
//           in_valid/in_inst/in_pc/in_npc/in_ready  - enqueue handshake
//           out_valid/out_inst/out_pc/out_npc/out_ready - head to decode
//           count    - occupied entries (0..DEPTH)
//           wfi_seen - a WFI was accepted since the last reset or flush
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  fetch_queue_if.slave  q
);

  localparam logic [31:0]    NOP      = 32'h00000013;
  localparam logic [31:0]    WFI      = 32'h10500073;
  localparam logic [PTR_W:0] FULL     = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;
  logic             wfi;
  logic             enq;
  logic             deq;
  entry_t           head_ent;

  // in_ready looks only at registered state, so a full queue never accepts
  // on the strength of a same-cycle dequeue.
  assign q.in_ready  = (cnt != FULL) && !wfi;
  assign q.out_valid = (cnt != '0);
  assign enq         = q.in_valid && q.in_ready && !flush;
  assign deq         = q.out_valid && q.out_ready && !flush;

  // An empty queue presents a NOP at PC 0 instead of stale storage.
  assign head_ent    = mem[head];
  assign q.out_inst  = q.out_valid ? head_ent.inst : NOP;
  assign q.out_pc    = q.out_valid ? head_ent.pc   : 32'h0;
  assign q.out_npc   = q.out_valid ? head_ent.npc  : 32'h0;
  assign q.count     = cnt;
  assign q.wfi_seen  = wfi;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      wfi  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      wfi  <= 1'b0;
    end else begin
      if (enq) begin
        mem[tail] <= '{inst: q.in_inst, pc: q.in_pc, npc: q.in_npc};
        tail      <= tail + PTR_ONE;
        if (q.in_inst == WFI) begin
          wfi <= 1'b1;
        end
      end
      if (deq) begin
        head <= head + PTR_ONE;
      end
      // Pointers wrap naturally; full/empty is decided by cnt alone.
      case ({enq, deq})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard testbench for fetch_queue
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] WFI  = 32'h10500073;
  localparam logic [31:0] ADDI = 32'h00100093;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  logic clock;
  logic reset;
  logic flush;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .q     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  ent_t        sb[$];
  bit          mwfi = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_inst, prev_pc, prev_npc;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and checker: evaluated on the falling edge, when the
  // inputs for the coming rising edge are stable.
  always @(negedge clock) begin
    bit exp_rdy, enq, deq;
    if (!reset) begin
      sb.delete();
      mwfi       = 1'b0;
      prev_stall = 1'b0;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    end else begin
      exp_rdy = (sb.size() < DEPTH) && !mwfi;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("count", 32'(bus.count), 32'(sb.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      chk("wfi_seen", 32'(bus.wfi_seen), 32'(mwfi));
      if (sb.size() == 0) begin
        chk("empty_inst", bus.out_inst, NOP);
        chk("empty_pc", bus.out_pc, 32'h0);
        chk("empty_npc", bus.out_npc, 32'h0);
      end else begin
        chk("head_inst", bus.out_inst, sb[0].inst);
        chk("head_pc", bus.out_pc, sb[0].pc);
        chk("head_npc", bus.out_npc, sb[0].npc);
      end
      if (prev_stall) begin
        chk("hold_inst", bus.in_inst, prev_inst);
        chk("hold_pc", bus.in_pc, prev_pc);
        chk("hold_npc", bus.in_npc, prev_npc);
      end
      prev_stall = bus.in_valid && !exp_rdy && !flush;
      prev_inst  = bus.in_inst;
      prev_pc    = bus.in_pc;
      prev_npc   = bus.in_npc;

      enq = bus.in_valid && exp_rdy && !flush;
      deq = (sb.size() != 0) && bus.out_ready && !flush;
      if (flush) begin
        sb.delete();
        mwfi = 1'b0;
      end else begin
        if (deq) void'(sb.pop_front());
        if (enq) begin
          sb.push_back('{inst: bus.in_inst, pc: bus.in_pc, npc: bus.in_npc});
          if (bus.in_inst == WFI) mwfi = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_inst  = inst;
    bus.in_npc   = pc + 32'd4;
  endtask

  task automatic drain(input int max_cycles);
    bus.out_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      cyc();
      if (!bus.out_valid) break;
    end
    chk("drain_done", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stalled;
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'h0;
    bus.in_pc     = 32'h0;
    bus.in_npc    = 32'h0;
    bus.out_ready = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    repeat (3) cyc();
    #3;
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_out_inst", bus.out_inst, NOP);
    chk("idle_count", 32'(bus.count), 32'd0);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Three entries, then drain in order.
    offer(32'h0, ADDI);
    cyc();
    offer(32'h4, ADDI);
    #3;
    chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_out_pc", bus.out_pc, 32'h0);
    cyc();
    offer(32'h8, ADDI);
    cyc();
    bus.in_valid = 1'b0;
    #3;
    chk("three_count", 32'(bus.count), 32'd3);
    drain(10);

    // Fill, stall a ninth entry, free one slot.
    for (int i = 0; i < DEPTH; i++) begin
      offer(32'(4 * i), ADDI);
      cyc();
    end
    offer(32'h20, ADDI);
    repeat (3) cyc();
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_count", 32'(bus.count), 32'(DEPTH));
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("slot_in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    bus.in_valid = 1'b0;
    drain(20);

    // Streaming with simultaneous enqueue and dequeue across pointer wrap.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      offer(32'(4 * i), ADDI);
      cyc();
      chk("stream_count", 32'(bus.count), 32'd1);
    end
    bus.in_valid = 1'b0;
    drain(10);

    // WFI closes the intake; entries ahead of and including it drain.
    offer(32'h10, ADDI);
    cyc();
    offer(32'h14, WFI);
    cyc();
    offer(32'h18, ADDI);
    repeat (4) cyc();
    chk("wfi_set", 32'(bus.wfi_seen), 32'd1);
    chk("wfi_in_ready", 32'(bus.in_ready), 32'd0);
    chk("wfi_count", 32'(bus.count), 32'd2);
    drain(10);
    repeat (2) cyc();
    chk("wfi_no_accept", 32'(bus.count), 32'd0);
    bus.in_valid = 1'b0;

    // Flush with enqueue and dequeue offered in the same cycle.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(32'(32'h100 + 4 * i), ADDI);
      cyc();
    end
    offer(32'h110, WFI);
    cyc();
    chk("pre_flush_count", 32'(bus.count), 32'd5);
    offer(32'h200, ADDI);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_wfi", 32'(bus.wfi_seen), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    chk("flush_absent", 32'(bus.count), 32'd0);

    // Asynchronous reset in mid-stream.
    for (int i = 0; i < 4; i++) begin
      offer(32'(32'h300 + 4 * i), ADDI);
      cyc();
    end
    bus.in_valid = 1'b0;
    cyc();
    chk("prereset_count", 32'(bus.count), 32'd4);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_count", 32'(bus.count), 32'd0);
    chk("areset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("areset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("areset_out_inst", bus.out_inst, NOP);
    @(negedge clock);
    cyc();
    reset = 1'b1;
    cyc();

    // Randomized traffic with fetch holding stalled offers.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      stalled = bus.in_valid && !bus.in_ready && !flush;
      cyc();
      if (!stalled) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_pc    = $urandom() & 32'hFFFF_FFFC;
        bus.in_npc   = $urandom() & 32'hFFFF_FFFC;
        bus.in_inst  = ($urandom_range(0, 9) == 0) ? WFI : $urandom();
      end
      bus.out_ready = ($urandom_range(0, 1) == 1);
      flush         = ($urandom_range(0, 24) == 0);
    end
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    drain(20);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Registered instruction FIFO between the fetch stage and the decoder.
- Buffers fetched instructions with their PC and NPC, and presents the oldest entry to decode over a valid/ready handshake.
- Its out_valid drives the decoder's valid input.
- Supports a branch-recovery flush, and stops accepting fetches once a WFI has been enqueued.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), width of the read and write pointers.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries (mispredict recovery).
- in_valid  in  1  fetch offers an entry this cycle.
- in_inst  in  32  fetched instruction word.
- in_pc  in  32  PC of in_inst.
- in_npc  in  32  predicted next PC.
- in_ready  out  1  queue can accept an entry this cycle.
- out_valid  out  1  head entry is valid; feeds the decoder's valid input.
- out_inst  out  32  head instruction.
- out_pc  out  32  head PC.
- out_npc  out  32  head NPC.
- out_ready  in  1  decode consumes the head this cycle.
- count  out  PTR_W+1  number of occupied entries (0..DEPTH).
- wfi_seen  out  1  a WFI has been accepted since the last reset or flush.

Behaviour:
- Reset (reset==0, asynchronous):
  - head, tail, count = 0; wfi_seen = 0.
  - out_valid = 0; in_ready = 1.
  - Entry storage contents are don't-care.
- Enqueue fires when in_valid && in_ready && !flush.
  - Writes {in_inst, in_pc, in_npc} at tail; tail increments modulo DEPTH.
- Dequeue fires when out_valid && out_ready && !flush.
  - head increments modulo DEPTH.
- Count update: +1 on enqueue only, -1 on dequeue only, unchanged when both fire (legal whenever 0 < count < DEPTH).
- in_ready = (count != DEPTH) && !wfi_seen. Combinational from registered state only; never depends on out_ready (no full-bypass).
- out_valid = (count != 0). out_inst, out_pc and out_npc are read combinationally from entry[head].
- When count==0: out_inst = 32'h00000013 (NOP), out_pc = 0, out_npc = 0, regardless of storage contents.
- Latency: an entry enqueued in cycle N is visible at the outputs in cycle N+1. No same-cycle pass-through when empty.
- Ordering: strict FIFO; every accepted entry is dequeued exactly once unless a flush removes it.
- WFI handling:
  - An enqueue with in_inst == 32'h10500073 sets wfi_seen in the next cycle, which drops in_ready.
  - The WFI entry itself is stored and drains normally; entries already queued ahead of it drain normally.
  - wfi_seen clears only on flush or reset.
- Flush (flush==1 at a clock edge):
  - head, tail, count and wfi_seen are cleared.
  - Any enqueue or dequeue offered in that cycle is discarded. Decode must treat the head presented during the flush cycle as not consumed.
  - The outputs show the empty state from the next cycle.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0. Full versus empty is resolved by count, not by pointer equality.
- Full: with count==DEPTH, in_valid is ignored and the offered entry is neither stored nor lost; fetch must hold it.
- Empty: with count==0, out_ready is ignored and count never underflows.
- Handshake rule for the fetch side: while in_valid && !in_ready, fetch holds in_inst, in_pc and in_npc stable. This is a bench assertion, not logic in this block.
- Reset asserted mid-operation: immediate return to the reset state; no entry survives.
- All registers are flops with asynchronous active-low clear; no latches.

Test Plan:
- Reset, then in_valid=0, out_ready=0 for 3 cycles -> out_valid=0, out_inst=32'h00000013, count=0, in_ready=1.
- Enqueue 3 entries (pc 0x0, 0x4, 0x8; inst ADDI x1,x0,1 = 32'h00100093) with out_ready=0 -> count=3 and out_pc=0x0 one cycle after the first enqueue. Then out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8, then out_valid=0.
- Fill 8 entries with out_ready=0 -> in_ready=0 and count=8. Offer a 9th entry (pc 0x20) and hold it -> not stored. Dequeue once -> in_ready=1 next cycle; 0x20 accepted and emerges 9th.
- Run 20 cycles with in_valid=1 and out_ready=1 every cycle -> count steady at 1 after cycle 1; pointers wrap past 7 with no loss; out_pc sequence 0x0, 0x4, ... contiguous.
- Enqueue pc 0x10, then pc 0x14 as 32'h10500073, then offer pc 0x18 -> wfi_seen=1 and in_ready=0 after the WFI. 0x18 is never accepted. Drain gives 0x10 then 0x14 (inst 32'h10500073).
- With 5 entries queued and wfi_seen=1, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, wfi_seen=0, in_ready=1; the offered entry is absent.
- Additionally, assert reset while count=4 mid-stream -> outputs return immediately (asynchronously) to the reset state.
